// File: rtl/alu_req_driver_if.sv
// Bundle of request, ALU-side and response signals for alu_req_driver.
// master is the driver's view; slave is the surrounding environment (requester, ALU, consumer).
interface alu_req_driver_if #(
  parameter int DATA_W     = 8,
  parameter int CTL_W      = 5,
  parameter int RESP_DEPTH = 4
);
  localparam int CW = $clog2(RESP_DEPTH) + 1;

  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic              req_cin;
  logic [CTL_W-1:0]  req_ctl;
  logic              valid_in;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              cin;
  logic [CTL_W-1:0]  ctl;
  logic              valid_out;
  logic [DATA_W-1:0] alu;
  logic              carry;
  logic              zero;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_alu;
  logic              rsp_carry;
  logic              rsp_zero;
  logic [CW-1:0]     outstanding;
  logic              err_spurious;
  logic              err_timeout;

  modport master (
    input  req_valid, req_a, req_b, req_cin, req_ctl,
    output req_ready,
    output valid_in, a, b, cin, ctl,
    input  valid_out, alu, carry, zero,
    output rsp_valid, rsp_alu, rsp_carry, rsp_zero,
    input  rsp_ready,
    output outstanding, err_spurious, err_timeout
  );

  modport slave (
    output req_valid, req_a, req_b, req_cin, req_ctl,
    input  req_ready,
    input  valid_in, a, b, cin, ctl,
    output valid_out, alu, carry, zero,
    input  rsp_valid, rsp_alu, rsp_carry, rsp_zero,
    output rsp_ready,
    input  outstanding, err_spurious, err_timeout
  );
endinterface

// File: rtl/alu_req_driver.sv
// Initiator for the ALU operand/result interface: credit-limited issue, in-flight tracking,
// FWFT response buffer and sticky spurious/timeout error flags.
module alu_req_driver #(
  parameter int DATA_W     = 8,
  parameter int CTL_W      = 5,
  parameter int RESP_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input logic             clk,
  input logic             reset,
  alu_req_driver_if.master bus
);
  localparam int CW = $clog2(RESP_DEPTH) + 1;
  localparam int PW = $clog2(RESP_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(RESP_DEPTH);
  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic              carry;
    logic              zero;
  } rsp_t;

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (v >= TIMEOUT_C) ? TIMEOUT_C : v + TW'(1);
  endfunction

  logic              vin_p1;
  logic [DATA_W-1:0] a_p1;
  logic [DATA_W-1:0] b_p1;
  logic              cin_p1;
  logic [CTL_W-1:0]  ctl_p1;
  logic [CW-1:0]     outstanding_p1;
  logic [CW-1:0]     count_p1;
  logic [PW-1:0]     wr_ptr_p1;
  logic [PW-1:0]     rd_ptr_p1;
  rsp_t              mem_p1 [RESP_DEPTH];
  logic [TW-1:0]     tcnt_p1;
  logic              err_spur_p1;
  logic              err_to_p1;

  logic [CW-1:0] credit_used;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] count_next;
  logic [TW-1:0] tcnt_next;
  logic          ready;
  logic          accept;
  logic          capture;
  logic          spurious;
  logic          pop;

  // Stage 0: handshake decisions from registered state and current inputs
  always_comb begin
    credit_used = outstanding_p1 + count_p1;
    ready       = !reset && !err_to_p1 && (credit_used < DEPTH_C);
    accept      = bus.req_valid && ready;
    // An op accepted this edge has not reached the ALU yet, so it cannot own this result.
    capture     = bus.valid_out && (outstanding_p1 != '0);
    spurious    = bus.valid_out && (outstanding_p1 == '0);
    pop         = (count_p1 != '0) && bus.rsp_ready;
    tcnt_next   = ((outstanding_p1 == '0) || capture) ? '0 : sat_inc(tcnt_p1);

    outstanding_next = outstanding_p1;
    case ({accept, capture})
      2'b10:   outstanding_next = outstanding_p1 + CW'(1);
      2'b01:   outstanding_next = outstanding_p1 - CW'(1);
      default: outstanding_next = outstanding_p1;
    endcase

    count_next = count_p1;
    case ({capture, pop})
      2'b10:   count_next = count_p1 + CW'(1);
      2'b01:   count_next = count_p1 - CW'(1);
      default: count_next = count_p1;
    endcase
  end

  // Stage 1: issue registers, credit/FIFO state, timeout and error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      vin_p1         <= 1'b0;
      a_p1           <= '0;
      b_p1           <= '0;
      cin_p1         <= 1'b0;
      ctl_p1         <= '0;
      outstanding_p1 <= '0;
      count_p1       <= '0;
      wr_ptr_p1      <= '0;
      rd_ptr_p1      <= '0;
      tcnt_p1        <= '0;
      err_spur_p1    <= 1'b0;
      err_to_p1      <= 1'b0;
      for (int i = 0; i < RESP_DEPTH; i++) mem_p1[i] <= '0;
    end else begin
      vin_p1 <= accept;
      if (accept) begin
        a_p1   <= bus.req_a;
        b_p1   <= bus.req_b;
        cin_p1 <= bus.req_cin;
        ctl_p1 <= bus.req_ctl;
      end
      outstanding_p1 <= outstanding_next;
      count_p1       <= count_next;
      if (capture) begin
        mem_p1[wr_ptr_p1] <= '{alu: bus.alu, carry: bus.carry, zero: bus.zero};
        wr_ptr_p1         <= wr_ptr_p1 + PW'(1);
      end
      if (pop) rd_ptr_p1 <= rd_ptr_p1 + PW'(1);
      tcnt_p1 <= tcnt_next;
      if (tcnt_next == TIMEOUT_C) err_to_p1 <= 1'b1;
      if (spurious) err_spur_p1 <= 1'b1;
    end
  end

  assign bus.req_ready    = ready;
  assign bus.valid_in     = vin_p1;
  assign bus.a            = a_p1;
  assign bus.b            = b_p1;
  assign bus.cin          = cin_p1;
  assign bus.ctl          = ctl_p1;
  assign bus.rsp_valid    = (count_p1 != '0);
  assign bus.rsp_alu      = mem_p1[rd_ptr_p1].alu;
  assign bus.rsp_carry    = mem_p1[rd_ptr_p1].carry;
  assign bus.rsp_zero     = mem_p1[rd_ptr_p1].zero;
  assign bus.outstanding  = outstanding_p1;
  assign bus.err_spurious = err_spur_p1;
  assign bus.err_timeout  = err_to_p1;
endmodule

// File: tb/tb_alu_req_driver.sv
// Bench for alu_req_driver: directed scenarios plus random traffic, checked every cycle
// against a queue-based transaction model; the bench also plays the ALU.
module tb_alu_req_driver;
  localparam int DATA_W     = 8;
  localparam int CTL_W      = 5;
  localparam int RESP_DEPTH = 4;
  localparam int TIMEOUT    = 16;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [4:0] ctl;
  } op_t;

  typedef struct packed {
    logic [7:0] alu;
    logic       carry;
    logic       zero;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_req_driver_if #(.DATA_W(DATA_W), .CTL_W(CTL_W), .RESP_DEPTH(RESP_DEPTH)) bus_if ();

  alu_req_driver #(
    .DATA_W(DATA_W), .CTL_W(CTL_W), .RESP_DEPTH(RESP_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus_if)
  );

  int total = 0;
  int bad   = 0;

  // Transaction-level reference state
  int   m_out;
  rsp_t resp_q[$];
  op_t  alu_q[$];
  bit   m_vin;
  op_t  m_last;
  bit   m_espur;
  bit   m_eto;
  int   m_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic rsp_t alu_fn(input op_t op);
    logic [8:0] s;
    case (op.ctl[1:0])
      2'd0:    s = {1'b0, op.a} + {1'b0, op.b} + 9'(op.cin);
      2'd1:    s = {1'b0, op.a & op.b};
      2'd2:    s = {1'b0, op.a | op.b};
      default: s = {1'b0, op.a ^ op.b};
    endcase
    return '{alu: s[7:0], carry: s[8], zero: (s[7:0] == 8'h00)};
  endfunction

  function automatic op_t mk_op(input logic [7:0] a, input logic [7:0] b,
                                input logic cin, input logic [4:0] ctl);
    return '{a: a, b: b, cin: cin, ctl: ctl};
  endfunction

  task automatic drive_req(input op_t op);
    bus_if.req_valid = 1'b1;
    bus_if.req_a     = op.a;
    bus_if.req_b     = op.b;
    bus_if.req_cin   = op.cin;
    bus_if.req_ctl   = op.ctl;
  endtask

  task automatic idle();
    bus_if.req_valid = 1'b0;
    bus_if.valid_out = 1'b0;
  endtask

  task automatic alu_return();
    rsp_t r;
    if (alu_q.size() > 0) begin
      r = alu_fn(alu_q.pop_front());
      bus_if.valid_out = 1'b1;
      bus_if.alu       = r.alu;
      bus_if.carry     = r.carry;
      bus_if.zero      = r.zero;
    end else begin
      bus_if.valid_out = 1'b0;
    end
  endtask

  task automatic compare();
    bit rdy;
    rdy = !reset && !m_eto && ((m_out + resp_q.size()) < RESP_DEPTH);
    chk("req_ready",    32'(bus_if.req_ready),    32'(rdy));
    chk("valid_in",     32'(bus_if.valid_in),     32'(m_vin));
    chk("a",            32'(bus_if.a),            32'(m_last.a));
    chk("b",            32'(bus_if.b),            32'(m_last.b));
    chk("cin",          32'(bus_if.cin),          32'(m_last.cin));
    chk("ctl",          32'(bus_if.ctl),          32'(m_last.ctl));
    chk("rsp_valid",    32'(bus_if.rsp_valid),    32'(resp_q.size() > 0));
    if (resp_q.size() > 0) begin
      chk("rsp_alu",    32'(bus_if.rsp_alu),      32'(resp_q[0].alu));
      chk("rsp_carry",  32'(bus_if.rsp_carry),    32'(resp_q[0].carry));
      chk("rsp_zero",   32'(bus_if.rsp_zero),     32'(resp_q[0].zero));
    end
    chk("outstanding",  32'(bus_if.outstanding),  32'(m_out));
    chk("err_spurious", 32'(bus_if.err_spurious), 32'(m_espur));
    chk("err_timeout",  32'(bus_if.err_timeout),  32'(m_eto));
  endtask

  // One clock: decide what the current inputs mean, advance the model at the edge, then check.
  task automatic cycle();
    bit   rdy, acc, cap, spur, pop;
    op_t  req;
    rsp_t res;
    rdy  = !reset && !m_eto && ((m_out + resp_q.size()) < RESP_DEPTH);
    acc  = bus_if.req_valid && rdy;
    cap  = bus_if.valid_out && (m_out > 0);
    spur = bus_if.valid_out && (m_out == 0);
    pop  = (resp_q.size() > 0) && bus_if.rsp_ready;
    req  = mk_op(bus_if.req_a, bus_if.req_b, bus_if.req_cin, bus_if.req_ctl);
    res  = '{alu: bus_if.alu, carry: bus_if.carry, zero: bus_if.zero};
    @(posedge clk);
    if (reset) begin
      m_out = 0; resp_q.delete(); alu_q.delete();
      m_vin = 0; m_last = '0; m_espur = 0; m_eto = 0; m_stall = 0;
    end else begin
      if (pop) void'(resp_q.pop_front());
      if (cap) resp_q.push_back(res);
      if (m_out == 0 || cap) m_stall = 0;
      else if (m_stall < TIMEOUT) m_stall++;
      if (m_stall == TIMEOUT) m_eto = 1;
      if (spur) m_espur = 1;
      m_out = m_out + (acc ? 1 : 0) - (cap ? 1 : 0);
      m_vin = acc;
      if (acc) m_last = req;
    end
    @(negedge clk);
    compare();
    if (m_vin) alu_q.push_back(m_last);
  endtask

  task automatic do_reset(input int n);
    idle();
    reset = 1'b1;
    repeat (n) cycle();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    bit   done;
    op_t  op;
    logic [7:0] sums [4];
    sums[0] = 8'd3; sums[1] = 8'd7; sums[2] = 8'd11; sums[3] = 8'd15;

    reset = 1'b1;
    bus_if.req_valid = 1'b0; bus_if.req_a = '0; bus_if.req_b = '0;
    bus_if.req_cin = 1'b0; bus_if.req_ctl = '0;
    bus_if.valid_out = 1'b0; bus_if.alu = '0; bus_if.carry = 1'b0; bus_if.zero = 1'b0;
    bus_if.rsp_ready = 1'b0;
    m_out = 0; m_vin = 0; m_last = '0; m_espur = 0; m_eto = 0; m_stall = 0;

    // Reset state
    do_reset(2);
    chk("rst_ready_low",  32'(bus_if.req_ready),   32'd0);
    chk("rst_rsp_alu",    32'(bus_if.rsp_alu),     32'd0);
    chk("rst_outstanding",32'(bus_if.outstanding), 32'd0);

    // Single op: 0x0F + 0x01
    drive_req(mk_op(8'h0F, 8'h01, 1'b0, 5'd0));
    cycle();
    idle();
    chk("single_vin",   32'(bus_if.valid_in),    32'd1);
    chk("single_a",     32'(bus_if.a),           32'h0F);
    chk("single_out1",  32'(bus_if.outstanding), 32'd1);
    alu_return();
    cycle();
    idle();
    chk("single_rspv",  32'(bus_if.rsp_valid),   32'd1);
    chk("single_alu",   32'(bus_if.rsp_alu),     32'h10);
    chk("single_out0",  32'(bus_if.outstanding), 32'd0);
    bus_if.rsp_ready = 1'b1;
    cycle();

    // Back-to-back issue into the credit limit
    bus_if.rsp_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      drive_req(mk_op(8'(2*i+1), 8'(2*i+2), 1'b0, 5'd0));
      cycle();
      if (bus_if.valid_in === 1'b1) n++;
    end
    idle();
    chk("b2b_vin_cycles", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      alu_return();
      cycle();
    end
    idle();
    chk("credit_full_ready", 32'(bus_if.req_ready),   32'd0);
    chk("credit_full_out",   32'(bus_if.outstanding), 32'd0);
    drive_req(mk_op(8'hAA, 8'h55, 1'b1, 5'd0));
    repeat (2) cycle();
    chk("credit_holdoff", 32'(bus_if.outstanding), 32'd0);
    idle();
    for (int i = 0; i < 4; i++) begin
      chk("b2b_order", 32'(bus_if.rsp_alu), 32'(sums[i]));
      bus_if.rsp_ready = 1'b1;
      cycle();
      if (i == 0) chk("credit_release", 32'(bus_if.req_ready), 32'd1);
    end

    // Spurious result with nothing in flight
    bus_if.valid_out = 1'b1; bus_if.alu = 8'h55; bus_if.carry = 1'b0; bus_if.zero = 1'b0;
    cycle();
    idle();
    chk("spur_flag", 32'(bus_if.err_spurious), 32'd1);
    chk("spur_rspv", 32'(bus_if.rsp_valid),    32'd0);
    repeat (3) cycle();
    chk("spur_sticky", 32'(bus_if.err_spurious), 32'd1);
    do_reset(1);
    chk("spur_cleared", 32'(bus_if.err_spurious), 32'd0);

    // Random traffic
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 2) != 0) begin
        op = mk_op(8'($urandom), 8'($urandom), 1'($urandom), 5'($urandom));
        drive_req(op);
      end else begin
        bus_if.req_valid = 1'b0;
      end
      if ($urandom_range(0, 1) == 1) alu_return();
      else bus_if.valid_out = 1'b0;
      bus_if.rsp_ready = 1'($urandom);
      cycle();
    end
    idle();
    bus_if.rsp_ready = 1'b1;
    done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      alu_return();
      cycle();
      done = (m_out == 0) && (resp_q.size() == 0) && (alu_q.size() == 0);
    end
    idle();
    chk("drain_done", 32'(done), 32'd1);

    // Timeout: op issued, ALU silent
    do_reset(1);
    bus_if.rsp_ready = 1'b0;
    drive_req(mk_op(8'h12, 8'h34, 1'b1, 5'd0));
    cycle();
    idle();
    n = 0;
    while (bus_if.err_timeout !== 1'b1 && n < 40) begin
      cycle();
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'(TIMEOUT));
    chk("timeout_ready",  32'(bus_if.req_ready), 32'd0);
    drive_req(mk_op(8'h01, 8'h01, 1'b0, 5'd0));
    alu_return();
    cycle();
    idle();
    chk("late_rspv",    32'(bus_if.rsp_valid),   32'd1);
    chk("late_alu",     32'(bus_if.rsp_alu),     32'h47);
    chk("late_blocked", 32'(bus_if.outstanding), 32'd0);
    bus_if.rsp_ready = 1'b1;
    cycle();

    // Reset with ops in flight and a response buffered
    do_reset(1);
    bus_if.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_req(mk_op(8'(16*i+9), 8'(i+3), 1'b0, 5'(i)));
      cycle();
    end
    idle();
    alu_return();
    cycle();
    idle();
    chk("mid_out2",  32'(bus_if.outstanding), 32'd2);
    chk("mid_rspv",  32'(bus_if.rsp_valid),   32'd1);
    reset = 1'b1;
    cycle();
    chk("mid_rst_vin",  32'(bus_if.valid_in),    32'd0);
    chk("mid_rst_a",    32'(bus_if.a),           32'd0);
    chk("mid_rst_rspv", 32'(bus_if.rsp_valid),   32'd0);
    chk("mid_rst_alu",  32'(bus_if.rsp_alu),     32'd0);
    chk("mid_rst_out",  32'(bus_if.outstanding), 32'd0);
    reset = 1'b0;
    drive_req(mk_op(8'hF0, 8'h10, 1'b0, 5'd0));
    cycle();
    idle();
    alu_return();
    cycle();
    idle();
    chk("post_rst_alu",   32'(bus_if.rsp_alu),   32'h00);
    chk("post_rst_carry", 32'(bus_if.rsp_carry), 32'd1);
    chk("post_rst_zero",  32'(bus_if.rsp_zero),  32'd1);
    bus_if.rsp_ready = 1'b1;
    repeat (2) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
